traffic_phase_scheduler: RTL

//  Tick-timed phase sequencer for a highway/country-road junction. Drives the
//  hwy/cntry lamp codes from a Moore FSM with per-phase dwell counters.

---
 rtl/traffic_phase_scheduler.sv | 122 ++++++++++++
 1 files changed

// File: rtl/traffic_phase_scheduler.sv
// Highway/country junction lamp sequencer: tick-timed Moore FSM with per-phase dwell counter.
// Lamps and phase update on the posedge that samples a qualifying tick; optional pedestrian walk under PED_WALK_EN.
// No flow control: tick and x are sampled levels, outputs are held until the next qualifying tick.
module traffic_phase_scheduler #(
  parameter int CNT_W  = 4,
  parameter int MIN_HG = 8,
  parameter int Y2R    = 3,
  parameter int R2G    = 2,
  parameter int MAX_CG = 10
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       x,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic [2:0] phase
);

  localparam int DMAX = (1 << CNT_W) - 1;

  if (CNT_W < 1 || MIN_HG < 1 || MIN_HG > DMAX || Y2R < 1 || Y2R > DMAX ||
      R2G < 1 || R2G > DMAX || MAX_CG < 1 || MAX_CG > DMAX) begin : g_bad_param
    $error("traffic_phase_scheduler: every dwell must lie in 1..2**CNT_W-1");
  end

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YEL = 2'd1;
  localparam logic [1:0] GRN = 2'd2;

  localparam logic [CNT_W-1:0] MIN_HG_M1 = CNT_W'(MIN_HG - 1);
  localparam logic [CNT_W-1:0] Y2R_M1    = CNT_W'(Y2R - 1);
  localparam logic [CNT_W-1:0] R2G_M1    = CNT_W'(R2G - 1);
  localparam logic [CNT_W-1:0] MAX_CG_M1 = CNT_W'(MAX_CG - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] elapsed;
  logic             hg_req;
  logic             cg_early;

`ifdef PED_WALK_EN
  logic ped_pend;
  assign hg_req   = x | ped_pend;
  // An active walk pins country green to its full maximum dwell.
  assign cg_early = ~x & ~walk;
`else
  assign hg_req   = x;
  assign cg_early = ~x;
`endif

  function automatic logic [3:0] lamps(input state_t s);
    case (s)
      HG:      lamps = {GRN, RED};
      HY:      lamps = {YEL, RED};
      CG:      lamps = {RED, GRN};
      CY:      lamps = {RED, YEL};
      default: lamps = {RED, RED};
    endcase
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      HG:  if (tick && hg_req && elapsed >= MIN_HG_M1)                nxt = HY;
      HY:  if (tick && elapsed == Y2R_M1)                             nxt = AR1;
      AR1: if (tick && elapsed == R2G_M1)                             nxt = CG;
      CG:  if (tick && (cg_early || elapsed == MAX_CG_M1))            nxt = CY;
      CY:  if (tick && elapsed == Y2R_M1)                             nxt = AR2;
      AR2: if (tick && elapsed == R2G_M1)                             nxt = HG;
      default:                                                        nxt = HG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= HG;
      elapsed <= '0;
      hwy     <= GRN;
      cntry   <= RED;
`ifdef PED_WALK_EN
      ped_pend <= 1'b0;
      walk     <= 1'b0;
`endif
    end else begin
      state          <= nxt;
      {hwy, cntry}   <= lamps(nxt);
      if (nxt != state)
        elapsed <= '0;
      else if (tick && elapsed != CNT_SAT)
        elapsed <= elapsed + 1'b1;
`ifdef PED_WALK_EN
      // A request landing on the CG-entry edge stays pending for the next cycle.
      if (state == AR1 && nxt == CG) begin
        walk     <= ped_pend;
        ped_pend <= ped_req;
      end else begin
        ped_pend <= ped_pend | ped_req;
        if (nxt != CG)
          walk <= 1'b0;
      end
`endif
    end
  end

  assign phase = state;

endmodule
